// File: rtl/xillybus_mem_initiator_if.sv
// Command/response and addressed-memory signal bundle for xillybus_mem_initiator.
// master: the initiator core. slave: host-side driver plus user memory.
interface xillybus_mem_initiator_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              session_open;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_wdata;
  logic [7:0]        cmd_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic              rsp_last;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_addr_update;
  logic              mem_wren;
  logic [7:0]        mem_wdata;
  logic              mem_full;
  logic              mem_rden;
  logic [7:0]        mem_rdata;
  logic              mem_empty;
  logic              mem_r_open;
  logic              mem_w_open;
  logic              err;

  modport master (
    input  session_open, cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_len,
           rsp_ready, mem_full, mem_rdata, mem_empty,
    output cmd_ready, rsp_valid, rsp_data, rsp_last, mem_addr, mem_addr_update,
           mem_wren, mem_wdata, mem_rden, mem_r_open, mem_w_open, err
  );

  modport slave (
    output session_open, cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_len,
           rsp_ready, mem_full, mem_rdata, mem_empty,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last, mem_addr, mem_addr_update,
           mem_wren, mem_wdata, mem_rden, mem_r_open, mem_w_open, err
  );
endinterface

// File: rtl/xillybus_mem_initiator.sv
// Core-side initiator for an 8-bit seekable Xillybus-style stream: turns seek /
// write / read-burst commands into the addr_update / wren / rden handshake of an
// addressed user memory and returns read bytes on a valid/ready port.
// Optional: define XILLYBUS_MEM_TIMEOUT_EN to abort stalls after TIMEOUT_CYCLES.
module xillybus_mem_initiator #(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     bus_clk,
  input  logic                     rst,
  xillybus_mem_initiator_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_SEEK, S_SETTLE, S_WRITE, S_READ, S_DRAIN} state_t;

  localparam logic [1:0] OP_SEEK  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [8:0]        remaining;
  logic              rd_pend, rd_last_pend;
  logic [7:0]        fifo_data [2];
  logic [1:0]        fifo_last;
  logic              rd_ptr, wr_ptr;
  logic [1:0]        fifo_cnt;
  logic              open_q, err_q;
  logic              accept_c, abort_c, timeout_c;
  logic              update_c, wren_c, rden_c, push_c, pop_c;

  // Stall limit must be reachable by the 16-bit stall counter.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("xillybus_mem_initiator: TIMEOUT_CYCLES out of range");
  end

  assign abort_c = (state != S_IDLE) && (!bus.session_open || timeout_c);
  assign push_c  = rd_pend && !abort_c;
  assign pop_c   = (fifo_cnt != 2'd0) && bus.rsp_ready;

  // State register.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and memory strobes; strobes are suppressed once the session drops.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    update_c  = 1'b0;
    wren_c    = 1'b0;
    rden_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.session_open && bus.cmd_valid) begin
          accept_c = 1'b1;
          case (bus.cmd_op)
            OP_SEEK:  state_nxt = S_SEEK;
            OP_WRITE: state_nxt = S_WRITE;
            OP_READ:  state_nxt = S_READ;
            default:  state_nxt = S_IDLE;
          endcase
        end
      end
      S_SEEK: begin
        update_c  = bus.session_open;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: state_nxt = S_IDLE;
      S_WRITE: begin
        wren_c = bus.session_open && !bus.mem_full;
        if (wren_c) state_nxt = S_IDLE;
      end
      S_READ: begin
        rden_c = bus.session_open && !bus.mem_empty &&
                 ((fifo_cnt + 2'(rd_pend)) < 2'd2) && (remaining != 9'd0);
        if (rden_c && remaining == 9'd1) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!rd_pend && fifo_cnt == 2'd0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_c) state_nxt = S_IDLE;
  end

  // Address, command latches, in-flight tracking, response FIFO and status.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= 8'd0;
      remaining    <= 9'd0;
      rd_pend      <= 1'b0;
      rd_last_pend <= 1'b0;
      fifo_data[0] <= 8'd0;
      fifo_data[1] <= 8'd0;
      fifo_last    <= 2'b00;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
      open_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      open_q <= bus.session_open;
      if (abort_c) err_q <= 1'b1;
      if (accept_c && bus.cmd_op == OP_SEEK)  addr_q  <= bus.cmd_addr;
      if (accept_c && bus.cmd_op == OP_WRITE) wdata_q <= bus.cmd_wdata;
      if (accept_c && bus.cmd_op == OP_READ)
        remaining <= (bus.cmd_len == 8'd0) ? 9'd256 : {1'b0, bus.cmd_len};
      if (wren_c || rden_c) addr_q <= addr_q + ADDR_W'(1);
      if (rden_c) remaining <= remaining - 9'd1;
      rd_pend      <= rden_c;
      rd_last_pend <= rden_c && (remaining == 9'd1);
      if (abort_c) begin
        rd_pend  <= 1'b0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        fifo_cnt <= 2'd0;
      end else begin
        if (push_c) begin
          fifo_data[wr_ptr] <= bus.mem_rdata;
          fifo_last[wr_ptr] <= rd_last_pend;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop_c) rd_ptr <= ~rd_ptr;
        fifo_cnt <= fifo_cnt + 2'(push_c) - 2'(pop_c);
      end
    end
  end

`ifdef XILLYBUS_MEM_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic        stall_c;

  assign stall_c   = (state == S_WRITE && bus.mem_full) ||
                     (state == S_READ && bus.mem_empty && remaining != 9'd0);
  assign timeout_c = stall_c && (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Stall counter restarts on any strobe or state change.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst)
      stall_cnt <= 16'd0;
    else if (!stall_c || wren_c || rden_c || state_nxt != state)
      stall_cnt <= 16'd0;
    else
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign timeout_c = 1'b0;
`endif

  assign bus.cmd_ready       = (state == S_IDLE) && bus.session_open;
  assign bus.rsp_valid       = (fifo_cnt != 2'd0);
  assign bus.rsp_data        = fifo_data[rd_ptr];
  assign bus.rsp_last        = (fifo_cnt != 2'd0) && fifo_last[rd_ptr];
  assign bus.mem_addr        = addr_q;
  assign bus.mem_addr_update = update_c;
  assign bus.mem_wren        = wren_c;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_rden        = rden_c;
  assign bus.mem_r_open      = open_q;
  assign bus.mem_w_open      = open_q;
  assign bus.err             = err_q;
endmodule

// File: tb/tb_xillybus_mem_initiator.sv
// Directed bench for xillybus_mem_initiator with a 1-cycle-latency 32-byte RAM model.
module tb_xillybus_mem_initiator;
  logic bus_clk;
  logic rst;
  logic load_pat;
  int   total;
  int   bad;
  logic [7:0] ram [32];

`ifdef XILLYBUS_MEM_TIMEOUT_EN
  localparam logic [4:0] T6_START = 5'd2;
`else
  localparam logic [4:0] T6_START = 5'd3;
`endif

  xillybus_mem_initiator_if #(.ADDR_W(5)) bus ();

  xillybus_mem_initiator #(.ADDR_W(5), .TIMEOUT_CYCLES(16)) dut (
    .bus_clk (bus_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  function automatic logic [7:0] pat(input logic [4:0] a);
    return 8'({3'b000, a} * 8'd7 + 8'd3);
  endfunction

  // Expected RAM contents after the writes of the first tests.
  function automatic logic [7:0] exp_byte(input logic [4:0] a);
    case (a)
      5'd31:   return 8'hA5;
      5'd0:    return 8'h3C;
      5'd1:    return 8'h77;
      default: return pat(a);
    endcase
  endfunction

  // Addressed memory model: read data appears one cycle after rden.
  always @(posedge bus_clk) begin
    if (load_pat) begin
      for (int i = 0; i < 32; i++) ram[i] <= pat(5'(i));
    end else if (bus.mem_wren) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_rden) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  // Offer a command until taken; returns in the first cycle after acceptance.
  task automatic issue(input logic [1:0] op, input logic [4:0] addr,
                       input logic [7:0] wd, input logic [7:0] len);
    bit done;
    done = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.cmd_len   = len;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (bus.cmd_ready) done = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accept", 32'(done), 32'd1);
  endtask

  // Collect a read burst of n bytes starting at address start.
  task automatic run_read(input int n, input logic [4:0] start, input bit tog,
                          input bit stall5, input string tag);
    int got, rdens, max_occ;
    got = 0; rdens = 0; max_occ = 0;
    for (int c = 0; c < 4000 && got < n; c++) begin
      bus.rsp_ready = tog ? c[0] : 1'b1;
      bus.mem_empty = stall5 && (c % 5 == 4);
      if (rdens - got > max_occ) max_occ = rdens - got;
      #1;
      if (bus.mem_rden) rdens++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (bus.rsp_data !== exp_byte(5'(start + 5'(got))) ||
            bus.rsp_last !== (got == n - 1)) begin
          check({tag, "_byte"}, {23'd0, bus.rsp_last, bus.rsp_data},
                {23'd0, (got == n - 1), exp_byte(5'(start + 5'(got)))});
        end
        got++;
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    bus.mem_empty = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(n));
    check({tag, "_rdens"}, 32'(rdens), 32'(n));
    check({tag, "_max_outstanding_le2"}, 32'(max_occ <= 2), 32'd1);
    repeat (3) tick();
    check({tag, "_ready_after"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_addr_after"}, 32'(bus.mem_addr), 32'(5'(start + 5'(n))));
  endtask

  initial begin
    int wrens, rdens, got;
    total = 0; bad = 0;
    rst = 1'b1; load_pat = 1'b1;
    bus.session_open = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
    bus.cmd_addr = 5'd0; bus.cmd_wdata = 8'd0; bus.cmd_len = 8'd0;
    bus.rsp_ready = 1'b1; bus.mem_full = 1'b0; bus.mem_empty = 1'b0;
    repeat (3) tick();
    load_pat = 1'b0;

    // Reset state
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_strobes", {29'd0, bus.mem_addr_update, bus.mem_wren, bus.mem_rden}, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    tick();
    bus.session_open = 1'b1;
    tick();
    tick();
    check("open_r", 32'(bus.mem_r_open), 32'd1);
    check("open_w", 32'(bus.mem_w_open), 32'd1);

    // Test 1: seek timing
    issue(2'b00, 5'h1A, 8'h00, 8'h00);
    check("t1_update", 32'(bus.mem_addr_update), 32'd1);
    check("t1_addr", 32'(bus.mem_addr), 32'h1A);
    check("t1_ready_seek", 32'(bus.cmd_ready), 32'd0);
    tick();
    check("t1_settle_quiet", {29'd0, bus.mem_addr_update, bus.mem_wren, bus.mem_rden}, 32'd0);
    check("t1_ready_settle", 32'(bus.cmd_ready), 32'd0);
    tick();
    check("t1_ready_back", 32'(bus.cmd_ready), 32'd1);

    // Test 2: writes across the address wrap
    issue(2'b00, 5'h1F, 8'h00, 8'h00);
    issue(2'b01, 5'h00, 8'hA5, 8'h00);
    check("t2_wren0", 32'(bus.mem_wren), 32'd1);
    check("t2_addr0", 32'(bus.mem_addr), 32'h1F);
    check("t2_wdata0", 32'(bus.mem_wdata), 32'hA5);
    issue(2'b01, 5'h00, 8'h3C, 8'h00);
    check("t2_wren1", 32'(bus.mem_wren), 32'd1);
    check("t2_addr1", 32'(bus.mem_addr), 32'h00);
    tick();
    check("t2_addr_after", 32'(bus.mem_addr), 32'h01);
    issue(2'b01, 5'h00, 8'h77, 8'h00);
    check("t2_addr2", 32'(bus.mem_addr), 32'h01);
    tick();

    // Test 3: short read burst
    issue(2'b00, 5'h1F, 8'h00, 8'h00);
    issue(2'b10, 5'h00, 8'h00, 8'd3);
    run_read(3, 5'h1F, 1'b0, 1'b0, "t3");

    // Test 4: 256-byte burst with backpressure and empty stalls
    issue(2'b10, 5'h00, 8'h00, 8'd0);
    run_read(256, 5'h02, 1'b1, 1'b1, "t4");

    // Test 5: write held off by mem_full
    bus.mem_full = 1'b1;
    issue(2'b01, 5'h00, 8'h5A, 8'h00);
    wrens = 0;
`ifdef XILLYBUS_MEM_TIMEOUT_EN
    repeat (16) begin
      if (bus.mem_wren) wrens++;
      tick();
    end
    check("t5_no_wren", 32'(wrens), 32'd0);
    check("t5_timeout_err", 32'(bus.err), 32'd1);
    check("t5_timeout_ready", 32'(bus.cmd_ready), 32'd1);
    check("t5_timeout_addr", 32'(bus.mem_addr), 32'd2);
    bus.mem_full = 1'b0;
    tick();
`else
    repeat (40) begin
      if (bus.mem_wren) wrens++;
      tick();
    end
    check("t5_no_wren", 32'(wrens), 32'd0);
    bus.mem_full = 1'b0;
    #1;
    check("t5_release_wren", 32'(bus.mem_wren), 32'd1);
    check("t5_release_addr", 32'(bus.mem_addr), 32'd2);
    check("t5_release_wdata", 32'(bus.mem_wdata), 32'h5A);
    tick();
    check("t5_single_wren", 32'(bus.mem_wren), 32'd0);
    check("t5_addr_after", 32'(bus.mem_addr), 32'd3);
    check("t5_ready", 32'(bus.cmd_ready), 32'd1);
    check("t5_err", 32'(bus.err), 32'd0);
`endif

    // Test 6: session drop mid-read
    issue(2'b10, 5'h00, 8'h00, 8'd10);
    got = 0; rdens = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      #1;
      if (bus.mem_rden) rdens++;
      if (bus.rsp_valid) begin
        check("t6_byte", 32'(bus.rsp_data), 32'(exp_byte(5'(T6_START + 5'(got)))));
        got++;
      end
      tick();
    end
    check("t6_got4", 32'(got), 32'd4);
    bus.session_open = 1'b0;
    #1;
    check("t6_drop_rden", 32'(bus.mem_rden), 32'd0);
    tick();
    check("t6_err", 32'(bus.err), 32'd1);
    check("t6_flushed", 32'(bus.rsp_valid), 32'd0);
    check("t6_r_open", 32'(bus.mem_r_open), 32'd0);
    check("t6_w_open", 32'(bus.mem_w_open), 32'd0);
    repeat (5) begin
      if (bus.mem_rden) rdens++;
      tick();
    end
    check("t6_rdens", 32'(rdens), 32'd5);
    check("t6_addr_hold", 32'(bus.mem_addr), 32'(5'(T6_START + 5'd5)));

    // Reset after abort returns everything to zero
    rst = 1'b1;
    #1;
    check("rst2_outputs",
          {19'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_last, bus.mem_addr_update,
           bus.mem_wren, bus.mem_rden, bus.mem_r_open, bus.mem_w_open, bus.err, bus.mem_addr},
          32'd0);
    check("rst2_data", {16'd0, bus.rsp_data, bus.mem_wdata}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
